// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the main-memory arbiter: FSM states, request
// source encoding and the line-offset width derivation.
package mem_arbiter_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_LINE_SIZE = 128;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE,
        MEM_ARB_WAIT,
        MEM_ARB_ACCESS,
        MEM_ARB_RESP
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        SRC_I,
        SRC_D,
        SRC_W
    } mem_arb_src_t;

    function automatic int off_bits_for(input int line_size);
        return $clog2(line_size / 8);
    endfunction

endpackage

// File: rtl/mem_write_buffer.sv
// Small synchronous FIFO of {addr, line} pairs holding D-cache writes until the
// arbiter drains them. A push into a full FIFO succeeds only when a pop coincides.
module mem_write_buffer #(
    parameter int AW    = 32,
    parameter int DW    = 128,
    parameter int DEPTH = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head_addr = r_addr[r_rd_ptr];
    assign head_data = r_data[r_rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_addr[r_wr_ptr] <= push_addr;
                r_data[r_wr_ptr] <= push_data;
                r_wr_ptr         <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads, D-cache reads and buffered D-cache line writes onto
// one single-ported line-wide memory with a fixed modelled access latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int LINE_SIZE   = DEF_LINE_SIZE,
    parameter int MEM_LINES   = 4096,
    parameter int MEM_LATENCY = 5,
    parameter int WB_DEPTH    = 2
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_read,
    input  logic [WORD_SIZE-1:0]         i_addr,
    output logic                         i_res,
    output logic [LINE_SIZE-1:0]         i_res_data,
    output logic [WORD_SIZE-1:0]         i_res_addr,
    input  logic                         d_read,
    input  logic [WORD_SIZE-1:0]         d_addr,
    output logic                         d_res,
    output logic [LINE_SIZE-1:0]         d_res_data,
    output logic [WORD_SIZE-1:0]         d_res_addr,
    input  logic                         d_wenable,
    input  logic [LINE_SIZE-1:0]         d_w_data,
    input  logic [WORD_SIZE-1:0]         d_w_addr,
    output logic                         m_en,
    output logic                         m_we,
    output logic [$clog2(MEM_LINES)-1:0] m_addr,
    output logic [LINE_SIZE-1:0]         m_wdata,
    input  logic [LINE_SIZE-1:0]         m_rdata,
    output logic                         wb_overflow
);

    localparam int OFF_BITS = off_bits_for(LINE_SIZE);
    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK =
        {{(WORD_SIZE - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    mem_arb_state_t       r_state;
    mem_arb_src_t         r_src;
    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_SIZE-1:0] r_addr;
    logic [LINE_SIZE-1:0] r_wdata;
    logic                 r_last_d;
    logic                 r_i_valid;
    logic [WORD_SIZE-1:0] r_i_addr;
    logic                 r_d_valid;
    logic [WORD_SIZE-1:0] r_d_addr;
    logic                 r_m_en;
    logic                 r_m_we;
    logic [IDX_BITS-1:0]  r_m_addr;
    logic [LINE_SIZE-1:0] r_m_wdata;
    logic                 r_i_res;
    logic                 r_d_res;
    logic                 r_overflow;

    logic                 w_wb_full;
    logic                 w_wb_empty;
    logic                 w_wb_pop;
    logic [WORD_SIZE-1:0] w_wb_head_addr;
    logic [LINE_SIZE-1:0] w_wb_head_data;
    logic                 w_gnt_valid;
    mem_arb_src_t         w_gnt_src;
    logic [WORD_SIZE-1:0] w_gnt_addr;
    mem_arb_src_t         w_acc_src;
    logic [WORD_SIZE-1:0] w_acc_addr;
    logic [LINE_SIZE-1:0] w_acc_wdata;
    logic                 w_go_access;

    mem_write_buffer #(
        .AW    (WORD_SIZE),
        .DW    (LINE_SIZE),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk       (clk),
        .rst       (rst),
        .push      (d_wenable),
        .push_addr (d_w_addr),
        .push_data (d_w_data),
        .pop       (w_wb_pop),
        .full      (w_wb_full),
        .empty     (w_wb_empty),
        .head_addr (w_wb_head_addr),
        .head_data (w_wb_head_data)
    );

    // Writes always win; between reads, a tie goes to the port not served last.
    always_comb begin
        w_gnt_valid = 1'b1;
        w_gnt_src   = SRC_W;
        w_gnt_addr  = w_wb_head_addr;
        if (!w_wb_empty) begin
            w_gnt_src  = SRC_W;
            w_gnt_addr = w_wb_head_addr;
        end else if (r_i_valid && (!r_d_valid || r_last_d)) begin
            w_gnt_src  = SRC_I;
            w_gnt_addr = r_i_addr;
        end else if (r_d_valid) begin
            w_gnt_src  = SRC_D;
            w_gnt_addr = r_d_addr;
        end else begin
            w_gnt_valid = 1'b0;
        end
    end

    // The access parameters come straight from the grant when latency 3 skips WAIT.
    always_comb begin
        w_acc_src   = r_src;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == MEM_ARB_IDLE) begin
            w_acc_src   = w_gnt_src;
            w_acc_addr  = w_gnt_addr;
            w_acc_wdata = w_wb_head_data;
        end
    end

    assign w_go_access = ((r_state == MEM_ARB_IDLE) && w_gnt_valid && (MEM_LATENCY == 3))
                      || ((r_state == MEM_ARB_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_wb_pop    = (r_state == MEM_ARB_ACCESS) && (r_src == SRC_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MEM_ARB_IDLE;
            r_src     <= SRC_I;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_last_d  <= 1'b1;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_res   <= 1'b0;
            r_d_res   <= 1'b0;
        end else begin
            r_m_en  <= 1'b0;
            r_m_we  <= 1'b0;
            r_i_res <= 1'b0;
            r_d_res <= 1'b0;
            case (r_state)
                MEM_ARB_IDLE: begin
                    if (w_gnt_valid) begin
                        r_src   <= w_gnt_src;
                        r_addr  <= w_gnt_addr;
                        r_wdata <= w_wb_head_data;
                        if (MEM_LATENCY == 3) begin
                            r_state <= MEM_ARB_ACCESS;
                        end else begin
                            r_state <= MEM_ARB_WAIT;
                            r_cnt   <= CNT_W'(MEM_LATENCY - 3);
                        end
                    end
                end
                MEM_ARB_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= MEM_ARB_ACCESS;
                    end
                end
                MEM_ARB_ACCESS: begin
                    if (r_src == SRC_W) begin
                        r_state <= MEM_ARB_IDLE;
                    end else begin
                        r_state <= MEM_ARB_RESP;
                        r_i_res <= (r_src == SRC_I);
                        r_d_res <= (r_src == SRC_D);
                    end
                end
                MEM_ARB_RESP: begin
                    r_state  <= MEM_ARB_IDLE;
                    r_last_d <= (r_src == SRC_D);
                end
                default: r_state <= MEM_ARB_IDLE;
            endcase
            if (w_go_access) begin
                r_m_en    <= 1'b1;
                r_m_we    <= (w_acc_src == SRC_W);
                r_m_addr  <= IDX_BITS'(w_acc_addr >> OFF_BITS);
                r_m_wdata <= (w_acc_src == SRC_W) ? w_acc_wdata : '0;
            end
        end
    end

    // A slot is busy from capture until its response pulse, so requests during
    // that window (including the response cycle) are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_valid <= 1'b0;
            r_i_addr  <= '0;
            r_d_valid <= 1'b0;
            r_d_addr  <= '0;
        end else begin
            if (r_i_res) begin
                r_i_valid <= 1'b0;
            end else if (!r_i_valid && i_read) begin
                r_i_valid <= 1'b1;
                r_i_addr  <= i_addr;
            end
            if (r_d_res) begin
                r_d_valid <= 1'b0;
            end else if (!r_d_valid && d_read) begin
                r_d_valid <= 1'b1;
                r_d_addr  <= d_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (d_wenable && w_wb_full && !w_wb_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign m_en        = r_m_en;
    assign m_we        = r_m_we;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign wb_overflow = r_overflow;
    assign i_res       = r_i_res;
    assign d_res       = r_d_res;
    assign i_res_data  = r_i_res ? m_rdata : '0;
    assign d_res_data  = r_d_res ? m_rdata : '0;
    assign i_res_addr  = r_i_res ? (r_addr & ALIGN_MASK) : '0;
    assign d_res_addr  = r_d_res ? (r_addr & ALIGN_MASK) : '0;

endmodule
